boot_rom_ctrl: RTL and testbench
================================

BOOT_ROM_CTRL -- requirements
Module: boot_rom_ctrl

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of TCDM slave ports, range 1..4.
REQ-002 Parameter ROM_ADDR_WIDTH, default 13: byte address width of the ROM space.
REQ-003 Parameter DATA_WIDTH, default 32: word width, one of 32 or 64.
REQ-004 Parameter OUT_REG, default 0: 1 adds an output register stage, so read latency is 1+OUT_REG.
REQ-005 Parameter BASE_ADDR, default SOC_MEM_MAP_BOOT_ROM_START_ADDR: ROM base byte address.
REQ-006 clk_i  in  1  clock; one clock domain; all flops are rising-edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 test_mode_i  in  1  test mode; no functional effect, passed through to the macro wrapper.
REQ-009 req_i  in  NUM_PORTS  per-port request.
REQ-010 add_i  in  NUM_PORTS x 32  per-port byte address.
REQ-011 wen_i  in  NUM_PORTS  per-port write-enable, active low (1 = read).
REQ-012 gnt_o  out  NUM_PORTS  per-port grant.
REQ-013 r_valid_o  out  NUM_PORTS  per-port response valid.
REQ-014 r_rdata_o  out  NUM_PORTS x DATA_WIDTH  per-port read data.
REQ-015 r_opc_o  out  NUM_PORTS  per-port error flag (1 = error).
REQ-016 rom_cen_o  out  1  macro chip enable, active low.
REQ-017 rom_addr_o  out  ROM_ADDR_WIDTH-log2(DATA_WIDTH/8)  macro word address.
REQ-018 rom_rdata_i  in  DATA_WIDTH  macro data, valid 1 cycle after rom_cen_o is low.

Function
REQ-019 Arbitration is round-robin: at most one gnt_o bit is high per cycle, and it is granted combinationally in the same cycle as its req_i.
REQ-020 The RR pointer resets to port 0 and, after a grant to port k, moves to (k+1) mod NUM_PORTS; with no grant it does not change.
REQ-021 Offset = add_i - BASE_ADDR, computed modulo 2^32.
REQ-022 An access is in range when offset < 2^ROM_ADDR_WIDTH.
REQ-023 A granted read that is in range drives rom_cen_o=0 and rom_addr_o=offset[ROM_ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low address bits are ignored.
REQ-024 A granted write (wen_i=0) or an out-of-range access keeps rom_cen_o=1 and is answered with r_opc_o=1 and r_rdata_o=0.
REQ-025 Responses use the same latency as successful reads, 1+OUT_REG cycles.
REQ-026 The response pipeline carries {valid, port index, err} for each stage.
REQ-027 r_valid_o asserts for exactly one cycle, only on the port that was granted.
REQ-028 Responses come back in grant order; back-to-back grants every cycle are sustained with no bubbles.
REQ-029 With OUT_REG=1, data is registered and r_valid_o/r_rdata_o/r_opc_o change only on clock edges.
REQ-030 When r_valid_o is low, r_rdata_o and r_opc_o for that port are 0.
REQ-031 When no request is granted, rom_cen_o=1 and rom_addr_o holds its previous value.
REQ-032 An address at exactly BASE_ADDR+2^ROM_ADDR_WIDTH is out of range.
REQ-033 An address below BASE_ADDR wraps in the subtraction and is out of range.

Reset
REQ-034 During reset: all pipeline valid bits are 0, r_valid_o=0, r_opc_o=0, r_rdata_o=0, rom_cen_o=1, rom_addr_o=0, and the RR pointer is 0.
REQ-035 gnt_o stays combinational during reset and is 0 whenever rst_ni=0.
REQ-036 Reset asserted mid-transaction discards in-flight responses; none are emitted after reset is released.

Verification
REQ-037 OUT_REG=0, port0 read at BASE_ADDR+0x8 -> gnt_o[0] in the same cycle, rom_addr_o=2; next cycle r_valid_o[0]=1, r_rdata_o[0]=macro word 2, r_opc_o[0]=0.
REQ-038 Ports 0 and 1 both request continuously for 4 cycles -> grants go 0,1,0,1 and each port receives 2 responses in order.
REQ-039 Port1 write to BASE_ADDR+0x4 -> rom_cen_o=1, and after 1+OUT_REG cycles r_valid_o[1]=1, r_opc_o[1]=1, r_rdata_o[1]=0.
REQ-040 Read at BASE_ADDR+0x2000 (ROM_ADDR_WIDTH=13) and at BASE_ADDR-4 -> both answered with r_opc_o=1 and no macro access.
REQ-041 OUT_REG=1, reads every cycle for 8 cycles -> 8 responses, each 2 cycles after its grant, with no gaps.
REQ-042 rst_ni pulsed low while 2 responses are in flight -> no r_valid_o afterwards, and the next grant goes to port 0.

Source files
------------

// File: rtl/boot_rom_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : boot_rom_ctrl_if
// Brief   : Multi-port TCDM request/response bundle for the boot ROM.
// Revision: 1.0
// ============================================================================
interface boot_rom_ctrl_if #(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_PORTS-1:0]                 req_i;
   logic [NUM_PORTS-1:0][31:0]           add_i;
   logic [NUM_PORTS-1:0]                 wen_i;
   logic [NUM_PORTS-1:0]                 gnt_o;
   logic [NUM_PORTS-1:0]                 r_valid_o;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rdata_o;
   logic [NUM_PORTS-1:0]                 r_opc_o;

   modport master (
      output req_i, add_i, wen_i,
      input  gnt_o, r_valid_o, r_rdata_o, r_opc_o
   );

   modport slave (
      input  req_i, add_i, wen_i,
      output gnt_o, r_valid_o, r_rdata_o, r_opc_o
   );
endinterface
`default_nettype wire

// File: rtl/boot_rom_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : boot_rom_ctrl
// Brief   : Round-robin multi-port front end for a single-port boot ROM macro.
// Revision: 1.0
// ============================================================================
`ifndef SOC_MEM_MAP_BOOT_ROM_START_ADDR
`define SOC_MEM_MAP_BOOT_ROM_START_ADDR 32'h1A00_0000
`endif

module boot_rom_ctrl #(
   parameter int          NUM_PORTS      = 2,
   parameter int          ROM_ADDR_WIDTH = 13,
   parameter int          DATA_WIDTH     = 32,
   parameter int          OUT_REG        = 0,
   parameter logic [31:0] BASE_ADDR      = `SOC_MEM_MAP_BOOT_ROM_START_ADDR
) (
   input  wire logic                                               clk_i,
   input  wire logic                                               rst_ni,
   input  wire logic                                               test_mode_i,
   boot_rom_ctrl_if.slave                                          bus,
   output logic                                                    rom_cen_o,
   output logic [ROM_ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]          rom_addr_o,
   input  wire logic [DATA_WIDTH-1:0]                              rom_rdata_i
);
   localparam int            OFF       = $clog2(DATA_WIDTH/8);
   localparam int            WAW       = ROM_ADDR_WIDTH - OFF;
   localparam int            PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

   logic [PW-1:0]         rr_q, rr_d;
   logic [WAW-1:0]        rom_addr_q, rom_addr_d;
   logic                  s0_valid_q, s0_err_q;
   logic [PW-1:0]         s0_port_q;

   logic [PW-1:0]         w_sel;
   logic                  w_gnt_any;
   logic [31:0]           w_offset;
   logic                  w_in_range, w_is_read, w_rom_access, w_err;
   logic [DATA_WIDTH-1:0] w_s0_data;
   logic                  w_out_valid, w_out_err;
   logic [PW-1:0]         w_out_port;
   logic [DATA_WIDTH-1:0] w_out_data;
   logic                  w_unused_test_mode;

   assign w_unused_test_mode = test_mode_i;

   // Search starts at the RR pointer; grants are suppressed while in reset.
   always_comb begin : p_arb
      int idx;
      w_gnt_any = 1'b0;
      w_sel     = rr_q;
      idx       = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (int'(rr_q) + i) % NUM_PORTS;
         if (!w_gnt_any && bus.req_i[idx]) begin
            w_gnt_any = 1'b1;
            w_sel     = PW'(idx);
         end
      end
      if (!rst_ni) begin
         w_gnt_any = 1'b0;
      end
   end

   always_comb begin
      bus.gnt_o        = '0;
      bus.gnt_o[w_sel] = w_gnt_any;
      rr_d             = rr_q;
      if (w_gnt_any) begin
         rr_d = (w_sel == LAST_PORT) ? '0 : w_sel + PW'(1);
      end
   end

   assign w_offset     = bus.add_i[w_sel] - BASE_ADDR;
   assign w_in_range   = (w_offset >> ROM_ADDR_WIDTH) == 32'd0;
   assign w_is_read    = bus.wen_i[w_sel];
   assign w_rom_access = w_gnt_any & w_is_read & w_in_range;
   assign w_err        = ~(w_is_read & w_in_range);

   assign rom_cen_o    = ~w_rom_access;
   assign rom_addr_o   = w_rom_access ? w_offset[ROM_ADDR_WIDTH-1:OFF] : rom_addr_q;
   assign rom_addr_d   = rom_addr_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         rom_addr_q <= '0;
         s0_valid_q <= 1'b0;
         s0_port_q  <= '0;
         s0_err_q   <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         rom_addr_q <= rom_addr_d;
         s0_valid_q <= w_gnt_any;
         s0_port_q  <= w_sel;
         s0_err_q   <= w_err;
      end
   end

   // Macro data lines up with stage 0; errored slots return zero data.
   assign w_s0_data = (s0_valid_q && !s0_err_q) ? rom_rdata_i : '0;

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  s1_valid_q, s1_err_q;
         logic [PW-1:0]         s1_port_q;
         logic [DATA_WIDTH-1:0] s1_data_q;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               s1_valid_q <= 1'b0;
               s1_port_q  <= '0;
               s1_err_q   <= 1'b0;
               s1_data_q  <= '0;
            end else begin
               s1_valid_q <= s0_valid_q;
               s1_port_q  <= s0_port_q;
               s1_err_q   <= s0_err_q;
               s1_data_q  <= w_s0_data;
            end
         end

         assign w_out_valid = s1_valid_q;
         assign w_out_port  = s1_port_q;
         assign w_out_err   = s1_err_q;
         assign w_out_data  = s1_data_q;
      end else begin : g_no_out_reg
         assign w_out_valid = s0_valid_q;
         assign w_out_port  = s0_port_q;
         assign w_out_err   = s0_err_q;
         assign w_out_data  = w_s0_data;
      end
   endgenerate

   always_comb begin
      bus.r_valid_o = '0;
      bus.r_opc_o   = '0;
      bus.r_rdata_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_out_valid && (w_out_port == PW'(p))) begin
            bus.r_valid_o[p] = 1'b1;
            bus.r_opc_o[p]   = w_out_err;
            bus.r_rdata_o[p] = w_out_data;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_boot_rom_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_boot_rom_ctrl
// Brief   : Vector bench driving an OUT_REG=0 and an OUT_REG=1 instance in lockstep.
// Revision: 1.0
// ============================================================================
module tb_boot_rom_ctrl;
   localparam logic [31:0] B = 32'h1A00_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cen0, cen1;
   logic [10:0] addr0, addr1;
   logic [31:0] rdata0 = '0, rdata1 = '0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   boot_rom_ctrl_if #(.NUM_PORTS(2), .DATA_WIDTH(32)) bus0 ();
   boot_rom_ctrl_if #(.NUM_PORTS(2), .DATA_WIDTH(32)) bus1 ();

   boot_rom_ctrl #(.NUM_PORTS(2), .ROM_ADDR_WIDTH(13), .DATA_WIDTH(32), .OUT_REG(0), .BASE_ADDR(B)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0), .bus(bus0.slave),
      .rom_cen_o(cen0), .rom_addr_o(addr0), .rom_rdata_i(rdata0));

   boot_rom_ctrl #(.NUM_PORTS(2), .ROM_ADDR_WIDTH(13), .DATA_WIDTH(32), .OUT_REG(1), .BASE_ADDR(B)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0), .bus(bus1.slave),
      .rom_cen_o(cen1), .rom_addr_o(addr1), .rom_rdata_i(rdata1));

   function automatic logic [31:0] rom_word(input int a);
      return 32'hB007_0000 | 32'(a);
   endfunction

   // ROM macro models: data valid one cycle after a low chip enable
   always @(posedge clk) if (!cen0) rdata0 <= rom_word(int'(addr0));
   always @(posedge clk) if (!cen1) rdata1 <= rom_word(int'(addr1));

   typedef struct {
      logic [1:0]  req, wen;
      logic [31:0] a0, a1;
      logic [1:0]  gnt;
      logic        cen;
      logic [10:0] addr;
      logic [1:0]  rv, opc;
      logic [31:0] rd0, rd1;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] req, input logic [1:0] wen,
                        input logic [31:0] a0, input logic [31:0] a1);
      bus0.req_i = req;  bus0.wen_i = wen;  bus0.add_i[0] = a0;  bus0.add_i[1] = a1;
      bus1.req_i = req;  bus1.wen_i = wen;  bus1.add_i[0] = a0;  bus1.add_i[1] = a1;
   endtask

   task automatic chk_bus(input string tag, input int d, input logic [1:0] gnt,
                          input logic cen, input logic [10:0] addr);
      if (d == 0) begin
         chk({tag, "/d0.gnt"},  64'(bus0.gnt_o), 64'(gnt));
         chk({tag, "/d0.cen"},  64'(cen0),       64'(cen));
         chk({tag, "/d0.addr"}, 64'(addr0),      64'(addr));
      end else begin
         chk({tag, "/d1.gnt"},  64'(bus1.gnt_o), 64'(gnt));
         chk({tag, "/d1.cen"},  64'(cen1),       64'(cen));
         chk({tag, "/d1.addr"}, 64'(addr1),      64'(addr));
      end
   endtask

   task automatic chk_resp(input string tag, input int d, input logic [1:0] rv,
                           input logic [1:0] opc, input logic [31:0] rd0, input logic [31:0] rd1);
      if (d == 0) begin
         chk({tag, "/d0.rvalid"}, 64'(bus0.r_valid_o),    64'(rv));
         chk({tag, "/d0.ropc"},   64'(bus0.r_opc_o),      64'(opc));
         chk({tag, "/d0.rdata0"}, 64'(bus0.r_rdata_o[0]), 64'(rd0));
         chk({tag, "/d0.rdata1"}, 64'(bus0.r_rdata_o[1]), 64'(rd1));
      end else begin
         chk({tag, "/d1.rvalid"}, 64'(bus1.r_valid_o),    64'(rv));
         chk({tag, "/d1.ropc"},   64'(bus1.r_opc_o),      64'(opc));
         chk({tag, "/d1.rdata0"}, 64'(bus1.r_rdata_o[0]), 64'(rd0));
         chk({tag, "/d1.rdata1"}, 64'(bus1.r_rdata_o[1]), 64'(rd1));
      end
   endtask

   function automatic logic [1:0] alt_gnt(input int c);
      if (c < 0 || c > 3) return 2'b00;
      return (c % 2 == 0) ? 2'b01 : 2'b10;
   endfunction

   initial begin
      logic [1:0]  prv, popc, e, e1, g;
      logic [31:0] prd0, prd1;

      //          req    wen    a0           a1         gnt    cen   addr     rv     opc    rd0                rd1
      vecs[0]  = '{2'b01, 2'b11, B+32'h8,     B,         2'b01, 1'b0, 11'h002, 2'b00, 2'b00, 32'h0,             32'h0};
      vecs[1]  = '{2'b11, 2'b11, B+32'h10,    B+32'h14,  2'b10, 1'b0, 11'h005, 2'b01, 2'b00, 32'hB007_0002,     32'h0};
      vecs[2]  = '{2'b11, 2'b11, B+32'h10,    B+32'h14,  2'b01, 1'b0, 11'h004, 2'b10, 2'b00, 32'h0,             32'hB007_0005};
      vecs[3]  = '{2'b11, 2'b11, B+32'h10,    B+32'h14,  2'b10, 1'b0, 11'h005, 2'b01, 2'b00, 32'hB007_0004,     32'h0};
      vecs[4]  = '{2'b11, 2'b11, B+32'h10,    B+32'h14,  2'b01, 1'b0, 11'h004, 2'b10, 2'b00, 32'h0,             32'hB007_0005};
      vecs[5]  = '{2'b10, 2'b01, B,           B+32'h4,   2'b10, 1'b1, 11'h004, 2'b01, 2'b00, 32'hB007_0004,     32'h0};
      vecs[6]  = '{2'b01, 2'b11, B+32'h2000,  B,         2'b01, 1'b1, 11'h004, 2'b10, 2'b10, 32'h0,             32'h0};
      vecs[7]  = '{2'b01, 2'b11, B-32'h4,     B,         2'b01, 1'b1, 11'h004, 2'b01, 2'b01, 32'h0,             32'h0};
      vecs[8]  = '{2'b00, 2'b11, B,           B,         2'b00, 1'b1, 11'h004, 2'b01, 2'b01, 32'h0,             32'h0};
      vecs[9]  = '{2'b01, 2'b11, B+32'h1FFE,  B,         2'b01, 1'b0, 11'h7FF, 2'b00, 2'b00, 32'h0,             32'h0};
      vecs[10] = '{2'b00, 2'b11, B,           B,         2'b00, 1'b1, 11'h7FF, 2'b01, 2'b00, 32'hB007_07FF,     32'h0};
      vecs[11] = '{2'b00, 2'b11, B,           B,         2'b00, 1'b1, 11'h7FF, 2'b00, 2'b00, 32'h0,             32'h0};

      // Reset state, with requests pending to show grants are held off
      rst_n = 1'b0;
      drive(2'b11, 2'b11, B, B + 32'h4);
      @(negedge clk); @(negedge clk); #2;
      chk_bus("reset", 0, 2'b00, 1'b1, 11'h0);
      chk_bus("reset", 1, 2'b00, 1'b1, 11'h0);
      chk_resp("reset", 0, 2'b00, 2'b00, 32'h0, 32'h0);
      chk_resp("reset", 1, 2'b00, 2'b00, 32'h0, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b00, 2'b11, B, B);

      prv = 2'b00; popc = 2'b00; prd0 = '0; prd1 = '0;
      for (int v = 0; v < 12; v++) begin
         @(negedge clk);
         drive(vecs[v].req, vecs[v].wen, vecs[v].a0, vecs[v].a1);
         #2;
         chk_bus($sformatf("v%0d", v), 0, vecs[v].gnt, vecs[v].cen, vecs[v].addr);
         chk_bus($sformatf("v%0d", v), 1, vecs[v].gnt, vecs[v].cen, vecs[v].addr);
         chk_resp($sformatf("v%0d", v), 0, vecs[v].rv, vecs[v].opc, vecs[v].rd0, vecs[v].rd1);
         chk_resp($sformatf("v%0d", v), 1, prv, popc, prd0, prd1);
         prv = vecs[v].rv; popc = vecs[v].opc; prd0 = vecs[v].rd0; prd1 = vecs[v].rd1;
      end

      // Streaming reads on port 0: latency 1 on dut0, 2 on dut1, no gaps
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         drive((c < 8) ? 2'b01 : 2'b00, 2'b11, B + 32'(4 * c), B);
         #2;
         chk($sformatf("stream%0d/d1.gnt", c), 64'(bus1.gnt_o), (c < 8) ? 64'h1 : 64'h0);
         e  = (c >= 1 && c <= 8) ? 2'b01 : 2'b00;
         e1 = (c >= 2 && c <= 9) ? 2'b01 : 2'b00;
         chk_resp($sformatf("stream%0d", c), 0, e, 2'b00, e[0] ? rom_word(c - 1) : 32'h0, 32'h0);
         chk_resp($sformatf("stream%0d", c), 1, e1, 2'b00, e1[0] ? rom_word(c - 2) : 32'h0, 32'h0);
      end

      // Reset with responses in flight; pointer currently at port 1
      repeat (2) begin
         @(negedge clk);
         drive(2'b11, 2'b11, B, B + 32'h40);
      end
      @(negedge clk);
      rst_n = 1'b0;
      drive(2'b00, 2'b11, B, B + 32'h40);
      #2;
      chk_bus("midrst", 0, 2'b00, 1'b1, 11'h0);
      chk_resp("midrst", 0, 2'b00, 2'b00, 32'h0, 32'h0);
      chk_resp("midrst", 1, 2'b00, 2'b00, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #2;
         chk_resp($sformatf("postrst%0d", c), 0, 2'b00, 2'b00, 32'h0, 32'h0);
         chk_resp($sformatf("postrst%0d", c), 1, 2'b00, 2'b00, 32'h0, 32'h0);
      end

      // Both ports requesting continuously: grants alternate starting at port 0
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive((c < 4) ? 2'b11 : 2'b00, 2'b11, B, B + 32'h40);
         #2;
         g  = alt_gnt(c);
         e  = alt_gnt(c - 1);
         e1 = alt_gnt(c - 2);
         chk_bus($sformatf("rr%0d", c), 0, g, (c < 4) ? 1'b0 : 1'b1,
                 (c < 4) ? (g[0] ? 11'h000 : 11'h010) : 11'h010);
         chk_resp($sformatf("rr%0d", c), 0, e, 2'b00,
                  e[0] ? rom_word(0) : 32'h0, e[1] ? rom_word(16) : 32'h0);
         chk_resp($sformatf("rr%0d", c), 1, e1, 2'b00,
                  e1[0] ? rom_word(0) : 32'h0, e1[1] ? rom_word(16) : 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
